// File: rtl/br_recover_ctrl.sv
// rtl/br_recover_ctrl.sv - branch resolution and misprediction recovery controller
// Optional statistics counters enabled by defining BP_STATS_EN.
module br_recover_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             is_br_EX,
    input  logic             br_EX,
    input  logic [31:0]      PC_EX,
    input  logic [31:0]      br_target,
    input  logic             jmp_EX,
    input  logic [31:0]      NPC_Pred_EX,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             fail,
    output logic             btb_upd_valid,
    output logic [31:0]      btb_upd_pc,
    output logic [31:0]      btb_upd_target,
    output logic             btb_upd_taken,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] real_npc;
    logic        mispredict;
    logic        in_idle;
    logic        resolve_br;
    logic        pred_unused;

    assign pc_plus4    = PC_EX + 32'd4;
    assign real_npc    = (is_br_EX && br_EX) ? br_target : pc_plus4;
    assign mispredict  = ex_valid && (real_npc != NPC_Pred_EX);
    assign in_idle     = (state == IDLE);
    assign resolve_br  = in_idle && ex_valid && is_br_EX;
    // The direction prediction is already folded into NPC_Pred_EX.
    assign pred_unused = jmp_EX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mispredict) state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        redirect_valid = 1'b0;
        flush_IF       = 1'b0;
        flush_ID       = 1'b0;
        if (state == REDIRECT) begin
            redirect_valid = 1'b1;
            flush_IF       = 1'b1;
            flush_ID       = 1'b1;
        end
    end

    // Instructions reaching EX while a redirect is pending are wrong-path and ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail           <= 1'b0;
            redirect_pc    <= 32'd0;
            btb_upd_valid  <= 1'b0;
            btb_upd_pc     <= 32'd0;
            btb_upd_target <= 32'd0;
            btb_upd_taken  <= 1'b0;
        end else begin
            fail          <= in_idle && mispredict;
            btb_upd_valid <= 1'b0;
            if (in_idle && mispredict) begin
                redirect_pc <= real_npc;
            end
            if (resolve_br) begin
                btb_upd_valid  <= 1'b1;
                btb_upd_pc     <= PC_EX;
                btb_upd_target <= br_target;
                btb_upd_taken  <= br_EX;
            end else if (in_idle && ex_valid && mispredict) begin
                // A non-branch was predicted taken: overwrite the aliasing entry as not-taken.
                btb_upd_valid  <= 1'b1;
                btb_upd_pc     <= PC_EX;
                btb_upd_target <= pc_plus4;
                btb_upd_taken  <= 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (resolve_br && (br_cnt != {CNT_W{1'b1}})) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (in_idle && mispredict && (miss_cnt != {CNT_W{1'b1}})) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`else
    assign br_cnt   = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_br_recover_ctrl.sv
// tb/tb_br_recover_ctrl.sv - randomized self-checking bench for br_recover_ctrl
module tb_br_recover_ctrl;
    localparam int TB_CNT_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                ex_valid, is_br_EX, br_EX, jmp_EX, redirect_ready;
    logic [31:0]         PC_EX, br_target, NPC_Pred_EX;
    logic                redirect_valid, flush_IF, flush_ID, fail;
    logic [31:0]         redirect_pc;
    logic                btb_upd_valid, btb_upd_taken;
    logic [31:0]         btb_upd_pc, btb_upd_target;
    logic [TB_CNT_W-1:0] br_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit                  m_busy;
    bit                  m_fail;
    logic [31:0]         m_rpc;
    bit                  m_bv, m_btk;
    logic [31:0]         m_bpc, m_bt;
    logic [TB_CNT_W-1:0] m_br, m_miss;
    logic [TB_CNT_W-1:0] exp_miss_sat;

    br_recover_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .is_br_EX(is_br_EX), .br_EX(br_EX),
        .PC_EX(PC_EX), .br_target(br_target), .jmp_EX(jmp_EX), .NPC_Pred_EX(NPC_Pred_EX),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_IF(flush_IF), .flush_ID(flush_ID), .fail(fail),
        .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
        .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] true_next_pc();
        return (is_br_EX && br_EX) ? br_target : PC_EX + 32'd4;
    endfunction

    // What the outputs must be after this edge, from the current (bench-driven) inputs.
    task automatic model_step();
        logic [31:0] rn;
        bit mp;
        if (rst) begin
            m_busy = 0; m_fail = 0; m_rpc = '0; m_bv = 0; m_bpc = '0; m_bt = '0; m_btk = 0;
            m_br = '0; m_miss = '0;
            return;
        end
        m_fail = 0;
        m_bv   = 0;
        if (m_busy) begin
            if (redirect_ready) m_busy = 0;
            return;
        end
        rn = true_next_pc();
        mp = ex_valid && (rn != NPC_Pred_EX);
        if (mp) begin
            m_busy = 1;
            m_fail = 1;
            m_rpc  = rn;
`ifdef BP_STATS_EN
            if (m_miss != {TB_CNT_W{1'b1}}) m_miss = m_miss + 1'b1;
`endif
        end
        if (ex_valid && is_br_EX) begin
            m_bv = 1; m_bpc = PC_EX; m_bt = br_target; m_btk = br_EX;
`ifdef BP_STATS_EN
            if (m_br != {TB_CNT_W{1'b1}}) m_br = m_br + 1'b1;
`endif
        end else if (mp) begin
            m_bv = 1; m_bpc = PC_EX; m_bt = PC_EX + 32'd4; m_btk = 0;
        end
    endtask

    task automatic compare_all();
        check("redirect_valid", 32'(redirect_valid), 32'(m_busy));
        check("flush_IF", 32'(flush_IF), 32'(m_busy));
        check("flush_ID", 32'(flush_ID), 32'(m_busy));
        check("fail", 32'(fail), 32'(m_fail));
        check("redirect_pc", redirect_pc, m_rpc);
        check("btb_upd_valid", 32'(btb_upd_valid), 32'(m_bv));
        check("btb_upd_pc", btb_upd_pc, m_bpc);
        check("btb_upd_target", btb_upd_target, m_bt);
        check("btb_upd_taken", 32'(btb_upd_taken), 32'(m_btk));
        check("br_cnt", 32'(br_cnt), 32'(m_br));
        check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit v, input bit isb, input bit tk, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic [31:0] pred);
        ex_valid = v; is_br_EX = isb; br_EX = tk; PC_EX = pc; br_target = tgt;
        NPC_Pred_EX = pred; jmp_EX = (pred != pc + 32'd4);
    endtask

    initial begin
        rst = 1; redirect_ready = 1;
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0);
        tick(); tick();
        check("reset_redirect_pc", redirect_pc, 32'h0);
        check("reset_fail", 32'(fail), 32'h0);
        rst = 0;

        // correct taken prediction
        drive(1, 1, 1, 32'h100, 32'h200, 32'h200); tick();
        check("t1_fail", 32'(fail), 32'h0);
        check("t1_rv", 32'(redirect_valid), 32'h0);
        check("t1_btb_v", 32'(btb_upd_valid), 32'h1);
        check("t1_btb_pc", btb_upd_pc, 32'h100);
        check("t1_btb_tgt", btb_upd_target, 32'h200);
        check("t1_btb_tk", 32'(btb_upd_taken), 32'h1);

        // taken branch predicted fall-through
        drive(1, 1, 1, 32'h100, 32'h200, 32'h104); tick();
        check("t2_fail", 32'(fail), 32'h1);
        check("t2_rv", 32'(redirect_valid), 32'h1);
        check("t2_flush", 32'(flush_IF & flush_ID), 32'h1);
        check("t2_rpc", redirect_pc, 32'h200);
        check("t2_btb_tk", 32'(btb_upd_taken), 32'h1);
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0); tick();
        check("t2_rv_one_cycle", 32'(redirect_valid), 32'h0);

        // non-branch predicted taken
        drive(1, 0, 0, 32'h40, 32'h0, 32'h80); tick();
        check("t3_rpc", redirect_pc, 32'h44);
        check("t3_btb_pc", btb_upd_pc, 32'h40);
        check("t3_btb_tgt", btb_upd_target, 32'h44);
        check("t3_btb_tk", 32'(btb_upd_taken), 32'h0);
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0); tick();

        // stalled handshake with wrong-path traffic
        drive(1, 1, 1, 32'h300, 32'h500, 32'h304); tick();
        for (int i = 0; i < 3; i++) begin
            redirect_ready = 0;
            drive(1, 1, 1, 32'h900 + 32'(i * 4), 32'hA00, 32'h0); tick();
            check("t4_rv_held", 32'(redirect_valid), 32'h1);
            check("t4_rpc_held", redirect_pc, 32'h500);
            check("t4_no_fail", 32'(fail), 32'h0);
            check("t4_no_btb", 32'(btb_upd_valid), 32'h0);
        end
        redirect_ready = 1; tick();
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0); tick();
        check("t4_idle", 32'(redirect_valid), 32'h0);

        // PC+4 wraps to zero
        drive(1, 1, 0, 32'hFFFF_FFFC, 32'h10, 32'h0); tick();
        check("t5_no_fail", 32'(fail), 32'h0);
        check("t5_btb_pc", btb_upd_pc, 32'hFFFF_FFFC);
        check("t5_btb_tk", 32'(btb_upd_taken), 32'h0);
        // reset while a redirect is pending
        drive(1, 0, 0, 32'h20, 32'h0, 32'h60); tick();
        redirect_ready = 0; drive(0, 0, 0, 32'h0, 32'h0, 32'h0); tick();
        rst = 1; tick();
        check("t5_rst_rv", 32'(redirect_valid), 32'h0);
        check("t5_rst_rpc", redirect_pc, 32'h0);
        check("t5_rst_btb_pc", btb_upd_pc, 32'h0);
        rst = 0; redirect_ready = 1; tick();

        // five mispredicts saturate the 2-bit miss counter
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 32'h1000 + 32'(i * 16), 32'h0, 32'h0); tick();
            drive(0, 0, 0, 32'h0, 32'h0, 32'h0); tick();
        end
`ifdef BP_STATS_EN
        exp_miss_sat = 2'd3;
`else
        exp_miss_sat = 2'd0;
`endif
        check("t6_miss_sat", 32'(miss_cnt), 32'(exp_miss_sat));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = {$urandom_range(0, 3) == 0 ? 30'h3FFF_FFFF : 30'($urandom), 2'b00};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  pc, {30'($urandom), 2'b00}, 32'h0);
            NPC_Pred_EX = ($urandom_range(0, 1) == 1) ? true_next_pc() :
                          (($urandom_range(0, 1) == 1) ? PC_EX + 32'd4 : br_target);
            redirect_ready = $urandom_range(0, 2) != 0;
            rst = $urandom_range(0, 99) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
